// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: pooling state encoding and the
// width-agnostic max compare used by the pooling blocks.
package cnn_pkg;

    localparam int DEFAULT_DATA_W = 16;
    // Widest value the shared compare handles; callers zero-extend into it.
    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PASS    = 2'd2
    } state_t;

    // Returns the larger of a and b, treating the low w bits as the value.
    // Ties return a, so the running maximum stays put.
    function automatic logic [MAX_W-1:0] max2(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input int unsigned      w,
        input bit               is_signed
    );
        logic signed [MAX_W-1:0] sa;
        logic signed [MAX_W-1:0] sb;
        logic                    a_ge;
        sa = $signed(a << (MAX_W - w)) >>> (MAX_W - w);
        sb = $signed(b << (MAX_W - w)) >>> (MAX_W - w);
        if (is_signed) a_ge = (sa >= sb);
        else           a_ge = (a >= b);
        return a_ge ? a : b;
    endfunction

endpackage

// File: rtl/max_pool_nway_max_tree.sv
// Combinational masked maximum across NUM_IN lanes; any_valid flags a
// non-empty mask so the caller knows max_value is meaningful.
module max_tree
    import cnn_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int NUM_IN = 2,
    parameter bit SIGNED = 1'b1
) (
    input  logic [NUM_IN*DATA_W-1:0] values,
    input  logic [NUM_IN-1:0]        mask,
    output logic [DATA_W-1:0]        max_value,
    output logic                     any_valid
);

    logic [MAX_W-1:0] acc;
    logic             hit;

    always_comb begin
        acc = '0;
        hit = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (mask[i]) begin
                if (!hit) acc = MAX_W'(values[i*DATA_W +: DATA_W]);
                else      acc = max2(acc, MAX_W'(values[i*DATA_W +: DATA_W]), DATA_W, SIGNED);
                hit = 1'b1;
            end
        end
        max_value = acc[DATA_W-1:0];
        any_valid = hit;
    end

endmodule

// File: rtl/max_pool_nway.sv
// N-lane max pooling: reduces WIN_DEPTH complete lane-groups into one
// maximum, with a bypass mode and a sticky duplicate-strobe flag.
module max_pool_nway
    import cnn_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int NUM_IN    = 2,
    parameter int WIN_DEPTH = 2,
    parameter bit SIGNED    = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pass,
    input  logic [NUM_IN-1:0]        in_done,
    input  logic [NUM_IN*DATA_W-1:0] in_value,
    output logic                     out_done,
    output logic [DATA_W-1:0]        out_value,
    output logic                     busy,
    output logic                     err_dup
);

    localparam int GW = ($clog2(WIN_DEPTH + 1) > 1) ? $clog2(WIN_DEPTH + 1) : 1;

    state_t              state;
    logic [NUM_IN-1:0]   lane_filled;
    logic [GW-1:0]       grp_cnt;
    logic [DATA_W-1:0]   run_max;

    logic                pass_mode;
    logic [NUM_IN-1:0]   accept;
    logic [NUM_IN-1:0]   pass_pick;
    logic [NUM_IN-1:0]   tree_mask;
    logic [DATA_W-1:0]   tree_max;
    logic                tree_any;
    logic [DATA_W-1:0]   merged;
    logic [NUM_IN-1:0]   filled_nxt;
    logic                grp_done;
    logic [GW-1:0]       grp_nxt;
    logic                win_done;
    logic                dup_collect;
    logic                dup_pass;

    // In bypass the tree sees only the lowest-index strobe, so it doubles as the selector.
    assign pass_mode   = (state == PASS) || ((state == IDLE) && pass);
    assign accept      = in_done & ~lane_filled;
    assign pass_pick   = in_done & (~in_done + NUM_IN'(1));
    assign tree_mask   = pass_mode ? pass_pick : accept;
    assign merged      = (state == IDLE) ? tree_max
                       : DATA_W'(max2(MAX_W'(run_max), MAX_W'(tree_max), DATA_W, SIGNED));
    assign filled_nxt  = lane_filled | accept;
    assign grp_done    = &filled_nxt;
    assign grp_nxt     = grp_cnt + GW'(grp_done);
    assign win_done    = grp_done && (grp_nxt == GW'(WIN_DEPTH));
    assign dup_collect = |(in_done & lane_filled);
    assign dup_pass    = |(in_done & ~pass_pick);
    assign busy        = (state == COLLECT);

    max_tree #(
        .DATA_W (DATA_W),
        .NUM_IN (NUM_IN),
        .SIGNED (SIGNED)
    ) u_max_tree (
        .values    (in_value),
        .mask      (tree_mask),
        .max_value (tree_max),
        .any_valid (tree_any)
    );

    // Registered stage: window state, running max and the output strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            lane_filled <= '0;
            grp_cnt     <= '0;
            run_max     <= '0;
            out_done    <= 1'b0;
            out_value   <= '0;
            err_dup     <= 1'b0;
        end else begin
            out_done <= 1'b0;
            if (pass_mode) begin
                if (tree_any) begin
                    out_value <= tree_max;
                    out_done  <= 1'b1;
                end
                if (dup_pass) err_dup <= 1'b1;
                state <= pass ? PASS : IDLE;
            end else begin
                if (dup_collect) err_dup <= 1'b1;
                if (tree_any) begin
                    if (win_done) begin
                        out_value   <= merged;
                        out_done    <= 1'b1;
                        lane_filled <= '0;
                        grp_cnt     <= '0;
                        state       <= IDLE;
                    end else if (grp_done) begin
                        lane_filled <= '0;
                        grp_cnt     <= grp_nxt;
                        run_max     <= merged;
                        state       <= COLLECT;
                    end else begin
                        lane_filled <= filled_nxt;
                        run_max     <= merged;
                        state       <= COLLECT;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_max_pool_nway.sv
// Self-checking bench for max_pool_nway: directed table, hand-written
// corner sequences, and randomized traffic against a window-level model.
module tb_max_pool_nway;

    logic        clk = 1'b0;
    logic        reset;
    logic        pass;
    logic [1:0]  in_done;
    logic [31:0] in_value;

    logic        s_done, u_done;
    logic [15:0] s_val, u_val;
    logic        s_busy, u_busy;
    logic        s_err, u_err;

    always #5 clk = ~clk;

    max_pool_nway #(.DATA_W(16), .NUM_IN(2), .WIN_DEPTH(2), .SIGNED(1'b1)) dut (
        .clk(clk), .reset(reset), .pass(pass), .in_done(in_done), .in_value(in_value),
        .out_done(s_done), .out_value(s_val), .busy(s_busy), .err_dup(s_err)
    );

    max_pool_nway #(.DATA_W(16), .NUM_IN(2), .WIN_DEPTH(2), .SIGNED(1'b0)) dut_u (
        .clk(clk), .reset(reset), .pass(pass), .in_done(in_done), .in_value(in_value),
        .out_done(u_done), .out_value(u_val), .busy(u_busy), .err_dup(u_err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic ps, input logic [1:0] d,
                         input logic [15:0] v0, input logic [15:0] v1);
        reset    = rst;
        pass     = ps;
        in_done  = d;
        in_value = {v1, v0};
        @(posedge clk);
        #1;
        reset   = 1'b0;
        in_done = 2'b00;
    endtask

    // Window-level reference: collect accepted samples, reduce when the window fills.
    logic [1:0]  m_fill;
    int          m_grp;
    logic [15:0] m_q[$];
    logic        m_done;
    logic [15:0] m_val_s, m_val_u;
    logic        m_err;

    function automatic bit greater(input logic [15:0] a, input logic [15:0] b, input bit sgn);
        if (sgn) return $signed(a) > $signed(b);
        return a > b;
    endfunction

    task automatic model_reset();
        m_fill = 2'b00; m_grp = 0; m_q.delete();
        m_done = 1'b0; m_val_s = '0; m_val_u = '0; m_err = 1'b0;
    endtask

    task automatic model_step(input logic rst, input logic [1:0] d,
                              input logic [15:0] v0, input logic [15:0] v1);
        logic [15:0] v[2];
        logic [15:0] bs, bu;
        if (rst) begin
            model_reset();
            return;
        end
        v[0] = v0; v[1] = v1;
        m_done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (d[i]) begin
                if (m_fill[i]) m_err = 1'b1;
                else begin
                    m_fill[i] = 1'b1;
                    m_q.push_back(v[i]);
                end
            end
        end
        if (m_fill == 2'b11) begin
            m_fill = 2'b00;
            m_grp++;
            if (m_grp == 2) begin
                bs = m_q[0]; bu = m_q[0];
                foreach (m_q[k]) begin
                    if (greater(m_q[k], bs, 1'b1)) bs = m_q[k];
                    if (greater(m_q[k], bu, 1'b0)) bu = m_q[k];
                end
                m_val_s = bs; m_val_u = bu; m_done = 1'b1;
                m_q.delete(); m_grp = 0;
            end
        end
    endtask

    typedef struct {
        logic [1:0]  d;
        logic [15:0] v0;
        logic [15:0] v1;
        logic        e_done;
        logic [15:0] e_val;
        logic        e_busy;
    } vec_t;

    vec_t tbl[14];

    initial begin
        logic        rr;
        logic [1:0]  rd;
        logic [15:0] r0, r1;

        tbl[0]  = '{2'b01, 16'd1,     16'd0,     1'b0, 16'd0,     1'b1};
        tbl[1]  = '{2'b10, 16'd0,     16'd2,     1'b0, 16'd0,     1'b1};
        tbl[2]  = '{2'b01, 16'd3,     16'd0,     1'b0, 16'd0,     1'b1};
        tbl[3]  = '{2'b10, 16'd0,     16'd4,     1'b1, 16'd4,     1'b0};
        tbl[4]  = '{2'b00, 16'd0,     16'd0,     1'b0, 16'd4,     1'b0};
        tbl[5]  = '{2'b01, 16'hFFFB,  16'd0,     1'b0, 16'd4,     1'b1};
        tbl[6]  = '{2'b10, 16'd0,     16'hFFFD,  1'b0, 16'd4,     1'b1};
        tbl[7]  = '{2'b01, 16'hFFF9,  16'd0,     1'b0, 16'd4,     1'b1};
        tbl[8]  = '{2'b10, 16'd0,     16'hFFFF,  1'b1, 16'hFFFF,  1'b0};
        tbl[9]  = '{2'b11, 16'd5,     16'd9,     1'b0, 16'hFFFF,  1'b1};
        tbl[10] = '{2'b11, 16'd7,     16'd2,     1'b1, 16'd9,     1'b0};
        tbl[11] = '{2'b11, 16'd1,     16'd1,     1'b0, 16'd9,     1'b1};
        tbl[12] = '{2'b11, 16'd1,     16'd1,     1'b1, 16'd1,     1'b0};
        tbl[13] = '{2'b00, 16'd0,     16'd0,     1'b0, 16'd1,     1'b0};

        pass = 1'b0; reset = 1'b1; in_done = 2'b00; in_value = '0;
        drive(1'b1, 1'b0, 2'b00, 16'd0, 16'd0);
        drive(1'b1, 1'b0, 2'b00, 16'd0, 16'd0);
        chk("reset_done",  16'(s_done), 16'd0);
        chk("reset_value", s_val,       16'd0);
        chk("reset_busy",  16'(s_busy), 16'd0);
        chk("reset_err",   16'(s_err),  16'd0);

        for (int i = 0; i < 14; i++) begin
            drive(1'b0, 1'b0, tbl[i].d, tbl[i].v0, tbl[i].v1);
            chk($sformatf("tbl%0d_done", i),  16'(s_done), 16'(tbl[i].e_done));
            chk($sformatf("tbl%0d_value", i), s_val,       tbl[i].e_val);
            chk($sformatf("tbl%0d_busy", i),  16'(s_busy), 16'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_err", i),   16'(s_err),  16'd0);
        end

        // Unsigned vs signed on the same window.
        drive(1'b0, 1'b0, 2'b01, 16'hFFFF, 16'd0);
        drive(1'b0, 1'b0, 2'b10, 16'd0,    16'd1);
        drive(1'b0, 1'b0, 2'b01, 16'd2,    16'd0);
        drive(1'b0, 1'b0, 2'b10, 16'd0,    16'd3);
        chk("unsigned_done",  16'(u_done), 16'd1);
        chk("unsigned_value", u_val,       16'hFFFF);
        chk("signed_value",   s_val,       16'd3);

        // Reset lands on the completing strobe: window discarded.
        drive(1'b0, 1'b0, 2'b01, 16'd1, 16'd0);
        drive(1'b0, 1'b0, 2'b10, 16'd0, 16'd2);
        drive(1'b0, 1'b0, 2'b01, 16'd3, 16'd0);
        drive(1'b1, 1'b0, 2'b10, 16'd0, 16'd4);
        chk("rst_mid_done",  16'(s_done), 16'd0);
        chk("rst_mid_value", s_val,       16'd0);
        chk("rst_mid_busy",  16'(s_busy), 16'd0);
        drive(1'b0, 1'b0, 2'b01, 16'd6, 16'd0);
        drive(1'b0, 1'b0, 2'b10, 16'd0, 16'd6);
        drive(1'b0, 1'b0, 2'b01, 16'd6, 16'd0);
        drive(1'b0, 1'b0, 2'b10, 16'd0, 16'd6);
        chk("after_rst_done",  16'(s_done), 16'd1);
        chk("after_rst_value", s_val,       16'd6);

        // Duplicate strobe on lane0 is ignored and flagged.
        drive(1'b0, 1'b0, 2'b01, 16'd5, 16'd0);
        chk("dup_pre_err", 16'(s_err), 16'd0);
        drive(1'b0, 1'b0, 2'b01, 16'd8, 16'd0);
        chk("dup_err",  16'(s_err),  16'd1);
        chk("dup_busy", 16'(s_busy), 16'd1);
        drive(1'b0, 1'b0, 2'b10, 16'd0, 16'd1);
        drive(1'b0, 1'b0, 2'b01, 16'd2, 16'd0);
        chk("dup_early_done", 16'(s_done), 16'd0);
        drive(1'b0, 1'b0, 2'b10, 16'd0, 16'd3);
        chk("dup_done",  16'(s_done), 16'd1);
        chk("dup_value", s_val,       16'd5);
        chk("dup_sticky", 16'(s_err), 16'd1);

        // Bypass mode.
        drive(1'b1, 1'b0, 2'b00, 16'd0, 16'd0);
        chk("pass_rst_err", 16'(s_err), 16'd0);
        drive(1'b0, 1'b1, 2'b00, 16'd0, 16'd0);
        chk("pass_busy", 16'(s_busy), 16'd0);
        drive(1'b0, 1'b1, 2'b10, 16'd0, 16'd7);
        chk("pass1_done",  16'(s_done), 16'd1);
        chk("pass1_value", s_val,       16'd7);
        chk("pass1_err",   16'(s_err),  16'd0);
        drive(1'b0, 1'b1, 2'b11, 16'd3, 16'd4);
        chk("pass2_value", s_val,       16'd3);
        chk("pass2_err",   16'(s_err),  16'd1);
        drive(1'b0, 1'b0, 2'b00, 16'd0, 16'd0);
        chk("pass_exit_done", 16'(s_done), 16'd0);

        // pass raised mid-window only takes effect after the window emits.
        drive(1'b0, 1'b0, 2'b01, 16'd10, 16'd0);
        chk("midpass_busy0", 16'(s_busy), 16'd1);
        drive(1'b0, 1'b1, 2'b10, 16'd0, 16'd11);
        chk("midpass_done1", 16'(s_done), 16'd0);
        chk("midpass_busy1", 16'(s_busy), 16'd1);
        drive(1'b0, 1'b1, 2'b01, 16'd12, 16'd0);
        chk("midpass_done2", 16'(s_done), 16'd0);
        drive(1'b0, 1'b1, 2'b10, 16'd0, 16'd13);
        chk("midpass_done3",  16'(s_done), 16'd1);
        chk("midpass_value3", s_val,       16'd13);
        chk("midpass_busy3",  16'(s_busy), 16'd0);
        drive(1'b0, 1'b1, 2'b01, 16'd20, 16'd0);
        chk("postpass_done",  16'(s_done), 16'd1);
        chk("postpass_value", s_val,       16'd20);
        drive(1'b0, 1'b0, 2'b00, 16'd0, 16'd0);
        drive(1'b0, 1'b0, 2'b00, 16'd0, 16'd0);

        // Randomized traffic against the reference model.
        drive(1'b1, 1'b0, 2'b00, 16'd0, 16'd0);
        model_reset();
        for (int n = 0; n < 400; n++) begin
            rr = ($urandom_range(0, 39) == 0);
            rd = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                r0 = 16'($urandom_range(0, 3));
                r1 = 16'($urandom_range(0, 3));
            end else begin
                r0 = 16'($urandom);
                r1 = 16'($urandom);
            end
            drive(rr, 1'b0, rd, r0, r1);
            model_step(rr, rd, r0, r1);
            chk("rnd_s_done",  16'(s_done), 16'(m_done));
            chk("rnd_s_value", s_val,       m_val_s);
            chk("rnd_s_busy",  16'(s_busy), 16'(m_q.size() != 0));
            chk("rnd_s_err",   16'(s_err),  16'(m_err));
            chk("rnd_u_done",  16'(u_done), 16'(m_done));
            chk("rnd_u_value", u_val,       m_val_u);
            chk("rnd_u_busy",  16'(u_busy), 16'(m_q.size() != 0));
            chk("rnd_u_err",   16'(u_err),  16'(m_err));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/max_pool_nway.md
Name: max_pool_nway

Overview:
- Parametrised successor to the team's two-input max_pooling block.
- Takes NUM_IN input lanes, each with a one-cycle done strobe and a value, and reduces WIN_DEPTH complete lane-groups into one maximum.
- Emits that maximum with a one-cycle out_done pulse.
- Adds a signed/unsigned compare option, a pass (bypass) mode and a duplicate-strobe error flag.
- Sits between the conv/accumulator outputs and the next-layer buffer.

Parameters:
- DATA_W, 16, width of each value.
- NUM_IN, 2, number of input lanes (>=1).
- WIN_DEPTH, 2, lane-groups per pooling window (>=1); window = NUM_IN*WIN_DEPTH samples.
- SIGNED, 1, 1 = two's-complement compare, 0 = unsigned compare.

Ports:
- clk  in  1  clock, all logic on posedge.
- reset  in  1  synchronous, active-high; clears all state.
- pass  in  1  bypass mode select.
- in_done  in  NUM_IN  per-lane one-cycle valid strobe.
- in_value  in  NUM_IN*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W].
- out_done  out  1  one-cycle result strobe.
- out_value  out  DATA_W  result; holds its last value between strobes.
- busy  out  1  high while a window is partially collected.
- err_dup  out  1  sticky error flag.

Behaviour:
- Reset state: out_done=0, out_value=0, busy=0, err_dup=0, lane_filled=0, grp_cnt=0, run_max=0, state=IDLE. Reset overrides all same-cycle strobes; a partial window is discarded and no output is produced.
- States: IDLE (nothing collected), COLLECT (>=1 sample in current window), PASS (bypass).
- pass is sampled only in IDLE.
  - IDLE with pass=1 goes to PASS.
  - PASS with pass=0 goes to IDLE on the next cycle.
  - pass changing in COLLECT has no effect until the window completes and the block returns to IDLE.
- Accepting a sample (COLLECT / IDLE with pass=0):
  - Each strobed lane whose lane_filled bit is 0 is accepted.
  - run_max becomes the max of run_max and all accepted lanes that cycle. Multiple simultaneous strobes are all accepted.
  - The first accepted sample of a window loads run_max directly; the reset value 0 never participates in a compare.
- Group completion: when every lane_filled bit is set (including same-cycle fills), lane_filled clears and grp_cnt increments.
- Window completion: when grp_cnt reaches WIN_DEPTH:
  - out_value <= final max, out_done=1 for one cycle. Latency is one cycle after the completing strobe.
  - grp_cnt <= 0 and state <= IDLE.
  - A strobe in the cycle after completion begins a new window with no gap.
- Duplicate strobe: a strobe on a lane already filled in the current group is ignored and sets err_dup. err_dup clears only on reset.
- Compare:
  - SIGNED=1: signed compare, so 16'hFFFF < 16'h0001.
  - SIGNED=0: unsigned compare. Equal values are stable either way.
- PASS mode:
  - Each cycle with any strobe gives out_value <= value of the lowest-index strobed lane, with out_done=1 the next cycle.
  - Other simultaneous strobes are dropped and set err_dup.
- busy = (state==COLLECT).
- Widths: grp_cnt is max(1,$clog2(WIN_DEPTH+1)) bits. No arithmetic growth; the output is exactly DATA_W.
- NUM_IN=1, WIN_DEPTH=1: every strobe produces an output one cycle later.

Decomposition:
- Shared package cnn_pkg holds:
  - the state enum (IDLE/COLLECT/PASS);
  - a max2 compare function parameterised by SIGNED;
  - the default DATA_W=16.
- One sub-module, max_tree: combinational, takes NUM_IN values plus a valid mask and returns the masked max and any_valid. Instantiated once.

Test Plan:
- Defaults; lane0=1, then lane1=2, then lane0=3, then lane1=4, on separate cycles -> out_done one cycle after the last strobe, out_value=4, busy falls with it.
- SIGNED=1; values 16'hFFFB, 16'hFFFD, 16'hFFF9, 16'hFFFF -> out_value=16'hFFFF (-1). SIGNED=0 with 16'hFFFF, 1, 2, 3 -> out_value=16'hFFFF.
- Both lanes strobed in the same cycle twice (5,9 then 7,2) -> out_value=9 after exactly 2 strobe cycles. A back-to-back next window (1,1,1,1) -> out_value=1 with no idle cycle.
- lane0=1, lane1=2, lane0=3, then reset=1 while lane1=4 is strobed -> no out_done, out_value stays 0, busy=0; a following window of 6,6,6,6 gives 6.
- Duplicate: lane0=5 then lane0=8 before lane1 -> err_dup=1 and 8 is ignored; completing with lane1=1 and group 2 = 2,3 -> out_value=5.
- pass=1 in IDLE; lane1=7 -> out_value=7 next cycle. lane0=3 and lane1=4 strobed together -> out_value=3 and err_dup=1. pass raised mid-window is ignored until that window's output.
